// File: rtl/ex_mem_reg_pkg.sv
// Shared pipeline defines: bus types, write-enable / stall constants,
// stall-vector bit ownership and the EX/MEM register mode decode.
// The stall-bit indices are reused by the id_ex and mem_wb registers.
package ex_mem_reg_pkg;

    // Bus widths and bus types.
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_W-1:0]      reg_bus_t;         // RegBus
    typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;    // RegAddrBus
    typedef logic [2*REG_W-1:0]    double_reg_bus_t;  // DoubleRegBus

    // Common constant values.
    localparam reg_bus_t ZERO_WORD     = '0;
    localparam logic     WRITE_ENABLE  = 1'b1;
    localparam logic     WRITE_DISABLE = 1'b0;
    localparam logic     STOP          = 1'b1;
    localparam logic     NO_STOP       = 1'b0;

    // Stall-vector bits owned by the execute and memory stages.
    localparam int EX_IDX  = 3;
    localparam int MEM_IDX = 4;

    // Per-edge behaviour of the EX/MEM register.
    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_BUBBLE = 2'd1,
        MODE_HOLD   = 2'd2
    } ex_mem_mode_e;

    // Execute stalled while memory runs -> bubble; both stalled -> hold.
    // Memory stalled with execute running cannot be issued by the stall
    // controller; holding is the safe answer because nothing is lost.
    function automatic ex_mem_mode_e decode_mode(input logic s_ex, input logic s_mem);
        ex_mem_mode_e mode;
        if (s_ex && !s_mem) begin
            mode = MODE_BUBBLE;
        end else if (s_ex || s_mem) begin
            mode = MODE_HOLD;
        end else begin
            mode = MODE_PASS;
        end
        return mode;
    endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures execute results (GPR and HI/LO writes) for the memory stage and
// parks the MADD/MSUB partial product and cycle counter while execute stalls.
// Modes per edge: PASS (advance), BUBBLE (insert NOP, park product), HOLD.
// Optional macro EX_MEM_FLUSH_EN adds a 'flush' input that clears every
// output on the edge (priority below rst, above all stall modes).
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6,
    parameter int EX_IDX  = ex_mem_reg_pkg::EX_IDX,
    parameter int MEM_IDX = ex_mem_reg_pkg::MEM_IDX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
`ifdef EX_MEM_FLUSH_EN
    input  logic                flush,
`endif
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o
);

    ex_mem_mode_e mode;

    logic [ADDR_W-1:0]   wd_q,    wd_d;
    logic                wreg_q,  wreg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   hi_q,    hi_d;
    logic [DATA_W-1:0]   lo_q,    lo_d;
    logic                whilo_q, whilo_d;
    logic [2*DATA_W-1:0] hilo_q,  hilo_d;
    logic [1:0]          cnt_q,   cnt_d;

    // Only the execute and memory bits matter here; fold the rest away.
    logic stall_unused;
    assign stall_unused = ^stall;

    // Decode the stall vector into this register's mode for the coming edge.
    always_comb begin
        mode = decode_mode(stall[EX_IDX], stall[MEM_IDX]);
    end

    // Next-state selection: advance, insert a NOP while parking the product, or hold.
    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        whilo_d = whilo_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;
        unique case (mode)
            MODE_PASS: begin
                wd_d    = ex_wd;
                wreg_d  = ex_wreg;
                wdata_d = ex_wdata;
                hi_d    = ex_hi;
                lo_d    = ex_lo;
                whilo_d = ex_whilo;
                hilo_d  = '0;
                cnt_d   = 2'd0;
            end
            MODE_BUBBLE: begin
                // A bubble must never carry a write enable downstream.
                wd_d    = '0;
                wreg_d  = WRITE_DISABLE;
                wdata_d = '0;
                hi_d    = '0;
                lo_d    = '0;
                whilo_d = WRITE_DISABLE;
                hilo_d  = hilo_i;
                cnt_d   = cnt_i;
            end
            default: begin
                // MODE_HOLD: keep everything as is.
            end
        endcase
    end

    // State register; reset (and flush when built in) clear every output.
    always_ff @(posedge clk) begin
`ifdef EX_MEM_FLUSH_EN
        if (rst || flush) begin
`else
        if (rst) begin
`endif
            wd_q    <= '0;
            wreg_q  <= WRITE_DISABLE;
            wdata_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            whilo_q <= WRITE_DISABLE;
            hilo_q  <= '0;
            cnt_q   <= 2'd0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            whilo_q <= whilo_d;
            hilo_q  <= hilo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come straight from the flops.
    assign mem_wd    = wd_q;
    assign mem_wreg  = wreg_q;
    assign mem_wdata = wdata_q;
    assign mem_hi    = hi_q;
    assign mem_lo    = lo_q;
    assign mem_whilo = whilo_q;
    assign hilo_o    = hilo_q;
    assign cnt_o     = cnt_q;

    // Flag the stall combination the controller should never produce.
    illegal_stall_a: assert property (@(posedge clk) disable iff (rst)
        !(!stall[EX_IDX] && stall[MEM_IDX]));

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios followed by random
// legal stall patterns, all compared against a rule-level reference model.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
`ifdef EX_MEM_FLUSH_EN
    logic        flush;
`endif
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model of the visible outputs.
    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata, hi, lo;
        logic        whilo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } outs_t;
    outs_t exp_o;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
`ifdef EX_MEM_FLUSH_EN
        .flush     (flush),
`endif
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .ex_hi     (ex_hi),
        .ex_lo     (ex_lo),
        .ex_whilo  (ex_whilo),
        .hilo_i    (hilo_i),
        .cnt_i     (cnt_i),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_hi    (mem_hi),
        .mem_lo    (mem_lo),
        .mem_whilo (mem_whilo),
        .hilo_o    (hilo_o),
        .cnt_o     (cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Apply the register's rules to one clock edge using the current inputs.
    task automatic model_edge();
        logic do_clear;
        do_clear = rst;
`ifdef EX_MEM_FLUSH_EN
        do_clear = do_clear || flush;
`endif
        if (do_clear) begin
            exp_o = '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0, hi: 32'd0, lo: 32'd0,
                      whilo: 1'b0, hilo: 64'd0, cnt: 2'd0};
        end else if (stall[3] && stall[4]) begin
            // hold: nothing changes
        end else if (stall[3]) begin
            exp_o = '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0, hi: 32'd0, lo: 32'd0,
                      whilo: 1'b0, hilo: hilo_i, cnt: cnt_i};
        end else begin
            exp_o = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, hi: ex_hi, lo: ex_lo,
                      whilo: ex_whilo, hilo: 64'd0, cnt: 2'd0};
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".wd"},    64'(mem_wd),    64'(exp_o.wd));
        check({tag, ".wreg"},  64'(mem_wreg),  64'(exp_o.wreg));
        check({tag, ".wdata"}, 64'(mem_wdata), 64'(exp_o.wdata));
        check({tag, ".hi"},    64'(mem_hi),    64'(exp_o.hi));
        check({tag, ".lo"},    64'(mem_lo),    64'(exp_o.lo));
        check({tag, ".whilo"}, 64'(mem_whilo), 64'(exp_o.whilo));
        check({tag, ".hilo"},  hilo_o,         exp_o.hilo);
        check({tag, ".cnt"},   64'(cnt_o),     64'(exp_o.cnt));
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_ex();
        ex_wd    = 5'($urandom);
        ex_wreg  = 1'($urandom);
        ex_wdata = $urandom;
        ex_hi    = $urandom;
        ex_lo    = $urandom;
        ex_whilo = 1'($urandom);
        hilo_i   = {$urandom, $urandom};
        cnt_i    = 2'($urandom);
    endtask

    initial begin
        exp_o = '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0, hi: 32'd0, lo: 32'd0,
                  whilo: 1'b0, hilo: 64'd0, cnt: 2'd0};
        rst = 1'b1;
        stall = 6'd0;
`ifdef EX_MEM_FLUSH_EN
        flush = 1'b0;
`endif
        rand_ex();
        ex_wreg = 1'b1;
        ex_whilo = 1'b1;
        cnt_i = 2'd1;

        // Reset with nonzero inputs: every output zero.
        tick("reset1");
        tick("reset2");
        check("reset.wreg", 64'(mem_wreg), 64'd0);
        check("reset.cnt",  64'(cnt_o),    64'd0);

        // PASS after release.
        @(negedge clk);
        rst = 1'b0;
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
        ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
        tick("pass");
        check("pass.wdata_const", 64'(mem_wdata), 64'hDEADBEEF);
        check("pass.wd_const",    64'(mem_wd),    64'd7);

        // BUBBLE: NOP downstream, product parked.
        @(negedge clk);
        stall = 6'b001111; ex_wreg = 1'b1; ex_wdata = 32'h55;
        hilo_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 2'd1;
        tick("bubble");
        check("bubble.wreg_const", 64'(mem_wreg), 64'd0);
        check("bubble.hilo_const", hilo_o, 64'h0000_0001_FFFF_FFFE);
        check("bubble.cnt_const",  64'(cnt_o), 64'd1);

        // MADD: next PASS edge returns cnt_o/hilo_o to zero.
        @(negedge clk);
        stall = 6'b000000;
        tick("madd_pass");
        check("madd.cnt_zero", 64'(cnt_o), 64'd0);

        // HOLD: load A5A5A5A5 then hold for 3 clocks with changing inputs.
        @(negedge clk);
        ex_wdata = 32'hA5A5A5A5;
        tick("hold_load");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 6'b011111;
            rand_ex();
            tick("hold");
            check("hold.wdata_const", 64'(mem_wdata), 64'hA5A5A5A5);
        end
        @(negedge clk);
        stall = 6'd0;
        tick("hold_release");

`ifdef EX_MEM_FLUSH_EN
        // Flush while holding a parked counter.
        @(negedge clk);
        stall = 6'b001000; rand_ex(); cnt_i = 2'd1;
        tick("flush_bubble");
        @(negedge clk);
        stall = 6'b011000;
        tick("flush_hold");
        @(negedge clk);
        flush = 1'b1;
        tick("flush");
        check("flush.cnt_const", 64'(cnt_o), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        stall = 6'd0;
`endif

        // Random legal traffic, with occasional reset.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rand_ex();
            stall = 6'($urandom);
            case ($urandom_range(0, 2))
                0: begin stall[3] = 1'b0; stall[4] = 1'b0; end
                1: begin stall[3] = 1'b1; stall[4] = 1'b0; end
                default: begin stall[3] = 1'b1; stall[4] = 1'b1; end
            endcase
            rst = ($urandom_range(0, 39) == 0);
`ifdef EX_MEM_FLUSH_EN
            flush = ($urandom_range(0, 29) == 0);
`endif
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
